// File: rtl/br_pred_ctrl.sv
// Branch predictor sequencer: in-flight prediction FIFO, resolution compare,
// predictor update, mispredict redirect/flush and saturating statistics.
module br_pred_ctrl #(
    parameter int QDEPTH       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid_i,
    input  logic [31:0] pred_pc_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_target_i,
    output logic        upd_valid_o,
    output logic        upd_taken_o,
    output logic [31:0] upd_addr_o,
    output logic [31:0] upd_target_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [15:0] branch_cnt_o,
    output logic [15:0] mispred_cnt_o
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state;
    logic [FW-1:0]   flush_cnt;
    logic [31:0]     q_pc     [QDEPTH];
    logic            q_taken  [QDEPTH];
    logic [31:0]     q_target [QDEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic            full, do_pop, do_push, mispred;
    logic [31:0]     h_pc, h_target, correct_pc;
    logic            h_taken;

    always_comb begin
        full       = (count == CW'(QDEPTH));
        h_pc       = q_pc[rd_ptr];
        h_taken    = q_taken[rd_ptr];
        h_target   = q_target[rd_ptr];
        do_pop     = (state == RUN) && res_valid_i && (count != '0);
        mispred    = (res_taken_i != h_taken) || (res_taken_i && (res_target_i != h_target));
        // A mispredicting pop makes any same-cycle push wrong-path.
        do_push    = (state == RUN) && pred_valid_i && (!full || do_pop) && !(do_pop && mispred);
        correct_pc = res_taken_i ? res_target_i : h_pc + 32'd4;
    end

    assign stall_o = full;

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_pc[wr_ptr]     <= pred_pc_i;
            q_taken[wr_ptr]  <= pred_taken_i;
            q_target[wr_ptr] <= pred_target_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= RUN;
            flush_cnt        <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            upd_valid_o      <= 1'b0;
            upd_taken_o      <= 1'b0;
            upd_addr_o       <= '0;
            upd_target_o     <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_o          <= 1'b0;
            err_o            <= 1'b0;
            branch_cnt_o     <= '0;
            mispred_cnt_o    <= '0;
        end else begin
            upd_valid_o      <= 1'b0;
            redirect_valid_o <= 1'b0;
            case (state)
                RUN: begin
                    if (res_valid_i && count == '0)
                        err_o <= 1'b1;
                    if (do_push)
                        wr_ptr <= wr_ptr + AW'(1);
                    if (do_pop) begin
                        rd_ptr       <= rd_ptr + AW'(1);
                        upd_valid_o  <= 1'b1;
                        upd_taken_o  <= res_taken_i;
                        upd_addr_o   <= h_pc;
                        upd_target_o <= res_target_i;
                        if (branch_cnt_o != 16'hFFFF)
                            branch_cnt_o <= branch_cnt_o + 16'd1;
                    end
                    count <= count + CW'(do_push) - CW'(do_pop);
                    if (do_pop && mispred) begin
                        if (mispred_cnt_o != 16'hFFFF)
                            mispred_cnt_o <= mispred_cnt_o + 16'd1;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= correct_pc;
                        flush_o          <= 1'b1;
                        flush_cnt        <= FW'(FLUSH_CYCLES);
                        state            <= FLUSH;
                        wr_ptr           <= '0;
                        rd_ptr           <= '0;
                        count            <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt <= FW'(1)) begin
                        state   <= RUN;
                        flush_o <= 1'b0;
                    end
                    flush_cnt <= flush_cnt - FW'(1);
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
